coef_loader: RTL and testbench
==============================

# coef_loader

Run-time coefficient writer for the FIR datapath, the write-side counterpart of the constant coefficient ROM. Accepts a framed valid/ready stream of coefficient words, writes them into an internal coefficient RAM at incrementing addresses, and checks the frame length. Exposes a synchronous ROM-style read port, so the filter tap sequencer fetches coefficients exactly as it does from a fixed ROM.

## Interface
- DATA_WIDTH, 16, coefficient word width
- ADDR_WIDTH, 5, coefficient address width
- NUM_COEF, 32, coefficients per frame; 1 ≤ NUM_COEF ≤ 2**ADDR_WIDTH

- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- s_valid_i  in  1  coefficient word valid
- s_ready_o  out  1  loader can accept
- s_data_i  in  DATA_WIDTH  coefficient word, two's complement
- s_last_i  in  1  final word of frame
- rd_addr_i  in  ADDR_WIDTH  tap read address
- rd_data_o  out  DATA_WIDTH  registered read data
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse on successful commit
- err_o  out  1  sticky frame-length error

## Operation
- Beat accepted when s_valid_i && s_ready_o; the accepted word is written at wr_cnt on that edge, and wr_cnt (width ADDR_WIDTH) increments.
- States:
  - IDLE: ready=1, wr_cnt=0. An accepted beat clears err_o, writes address 0, and goes to LOAD.
  - LOAD: ready=1. Every accepted beat writes.
  - DISCARD: ready=1. Beats are accepted and dropped until s_last_i, then IDLE.
  - COMMIT: ready=0, busy=1, done_o=1 for exactly one cycle, then IDLE.
- Length rules for the accepted beat at index wr_cnt; these apply equally when the first beat is accepted in IDLE:
  - s_last_i && wr_cnt==NUM_COEF-1 → COMMIT.
  - s_last_i && wr_cnt<NUM_COEF-1 (short frame) → err_o=1, IDLE.
  - !s_last_i && wr_cnt==NUM_COEF-1 (long frame) → err_o=1, DISCARD. The beats written up to that point stay written.
  - Otherwise the state is unchanged.
- NUM_COEF==1: a single beat with s_last_i in IDLE goes directly to COMMIT.
- busy_o = (state != IDLE).
- Read port: rd_data_o <= mem[active][rd_addr_i] every cycle, with no enable. rd_addr_i ≥ NUM_COEF returns the stored content.
- Same-address read/write in one cycle is read-first and returns the old word.
- RAM contents are initialised to zero at configuration and are never cleared by reset.
- Reset (asynchronous, any state, including mid-frame): state=IDLE, wr_cnt=0, err_o=0, done_o=0, rd_data_o=0, active bank=0. RAM contents are retained. A partially loaded frame is abandoned; the next beat is treated as word 0.

## Timing
- Write latency: the word is in RAM on the edge that accepts it.
- Read latency: 1 cycle, with the address sampled at edge N and data valid after edge N.
- done_o is high during the cycle after the last beat is accepted.
- s_ready_o is low only in COMMIT, so a maximum-rate frame of NUM_COEF beats occupies NUM_COEF+1 cycles.
- err_o rises on the edge accepting the offending beat.

## Configuration
- COEF_SHADOW_EN defined:
  - Two banks. Writes go to the inactive bank; reads use the active bank.
  - The active bank toggles on the edge leaving COMMIT. Reads sampled on that edge still return the old set; the new set is visible from the following sample.
  - Erroneous frames never become active, and the filter never sees a mixed set.
- COEF_SHADOW_EN undefined:
  - Single bank; writes and reads share it, and no swap takes place.
  - A read during a load may observe a mixed old/new set.
  - An erroneous frame leaves its partially written words in place.

## Structure
- fir_pkg holds the loader_state_t enum (IDLE, LOAD, DISCARD, COMMIT).
- Sub-module coef_ram:
  - simple dual-port, one write port and one registered read port, read-first.
  - One instance with COEF_SHADOW_EN, where bank select is the MSB of the address; otherwise one single-bank instance.

## Test plan
- Reset mid-frame after 3 beats:
  - Outputs at reset values and s_ready_o=1.
  - A fresh 32-beat frame of values k·3 gives done_o one cycle after beat 31; reads of addresses 0..31 return 0,3,…,93.
- Short frame, s_last_i on beat 10:
  - err_o=1, done_o stays 0.
  - With COEF_SHADOW_EN, reads still return the previous set.
- Long frame of 40 beats:
  - err_o=1 at beat 32, beats 32..39 accepted and dropped, state IDLE after beat 39.
  - The next valid frame clears err_o on its first beat.
- Back-to-back frames with s_valid_i held high:
  - s_ready_o is low exactly one cycle per frame.
  - Two frames complete in 66 cycles, with two done_o pulses.
- Same-cycle read/write of address 5 without COEF_SHADOW_EN, old=0x0011, new=0x7FFF:
  - rd_data_o=0x0011 next cycle, 0x7FFF the cycle after.
- NUM_COEF=1:
  - A single beat 0x8000 with s_last_i gives COMMIT and done_o; address 0 then reads 0x8000.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types for the FIR coefficient path: loader FSM state encoding.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        DISCARD = 2'd2,
        COMMIT  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/coef_ram.sv
// Simple dual-port coefficient RAM: one write port, one registered read-first read port.
module coef_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Zero at configuration; reset never touches the array, only the read register.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // The read samples the pre-edge array, so a same-address write returns the old word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/coef_loader.sv
// Run-time FIR coefficient loader: framed stream in, ROM-style registered read port out.
// Define COEF_SHADOW_EN for a double-buffered (shadow bank) coefficient set.
module coef_loader
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_COEF   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output loader_state_t         state_o
);

    // Stream handshake: a beat transfers on a rising edge where s_valid_i && s_ready_o;
    // s_ready_o drops only while committing, and data/last are sampled with the beat.

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_COEF - 1);

    loader_state_t         state;
    loader_state_t         state_next;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] wr_cnt_next;
    logic                  err_next;
    logic                  wr_en;
    logic                  accept;
    logic                  at_end;

    assign s_ready_o = (state != COMMIT);
    assign accept    = s_valid_i && s_ready_o;
    assign at_end    = (wr_cnt == LAST_IDX);
    assign busy_o    = (state != IDLE);
    assign done_o    = (state == COMMIT);
    assign state_o   = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            wr_cnt <= '0;
            err_o  <= 1'b0;
        end else begin
            state  <= state_next;
            wr_cnt <= wr_cnt_next;
            err_o  <= err_next;
        end
    end

    always_comb begin
        state_next  = state;
        wr_cnt_next = wr_cnt;
        err_next    = err_o;
        wr_en       = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    // A new frame starts clean; a length fault on this same beat still wins.
                    if (state == IDLE) begin
                        err_next = 1'b0;
                    end
                    if (s_last_i && at_end) begin
                        state_next  = COMMIT;
                        wr_cnt_next = '0;
                    end else if (s_last_i) begin
                        err_next    = 1'b1;
                        state_next  = IDLE;
                        wr_cnt_next = '0;
                    end else if (at_end) begin
                        err_next    = 1'b1;
                        state_next  = DISCARD;
                        wr_cnt_next = '0;
                    end else begin
                        state_next  = LOAD;
                        wr_cnt_next = wr_cnt + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (accept && s_last_i) begin
                    state_next = IDLE;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next  = IDLE;
                wr_cnt_next = '0;
            end
        endcase
    end

`ifdef COEF_SHADOW_EN
    logic active;

    // The swap happens on the edge leaving COMMIT; that edge's read still uses the old bank.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active <= 1'b0;
        end else if (state == COMMIT) begin
            active <= ~active;
        end
    end

    coef_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en),
        .wr_addr_i ({~active, wr_cnt}),
        .wr_data_i (s_data_i),
        .rd_addr_i ({active, rd_addr_i}),
        .rd_data_o (rd_data_o)
    );
`else
    coef_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_cnt),
        .wr_data_i (s_data_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o)
    );
`endif

endmodule

// File: tb/tb_coef_loader.sv
// Bench for coef_loader: directed scenarios plus random frames against a frame-level model.
module tb_coef_loader;
    import fir_pkg::*;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int N  = 32;
`ifdef COEF_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance (NUM_COEF = 32)
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data  = '0;
    logic          s_last  = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          busy, done, err;
    loader_state_t state;

    // single-coefficient instance (NUM_COEF = 1)
    logic          v1 = 1'b0;
    logic          r1;
    logic [DW-1:0] d1 = '0;
    logic          l1 = 1'b0;
    logic [AW-1:0] ra1 = '0;
    logic [DW-1:0] rdd1;
    logic          b1, dn1, e1;
    loader_state_t st1;

    coef_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_COEF(N)) dut (
        .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_data_i(s_data), .s_last_i(s_last), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .busy_o(busy), .done_o(done), .err_o(err), .state_o(state)
    );

    coef_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_COEF(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .s_valid_i(v1), .s_ready_o(r1),
        .s_data_i(d1), .s_last_i(l1), .rd_addr_i(ra1), .rd_data_o(rdd1),
        .busy_o(b1), .done_o(dn1), .err_o(e1), .state_o(st1)
    );

    // ---------------- scoreboard / model ----------------
    int n_vec = 0;
    int n_bad = 0;
    int n_done = 0;
    int rd_hold = -1;
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] m_mem [2][N];
    int m_count;        // words taken into the current frame
    bit m_discard;      // dropping the tail of an over-long frame
    bit m_commit;       // the cycle after a good frame's last beat
    bit m_err;
    bit m_active;       // bank the reader sees

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        assert (act === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] next_rd();
        if (rd_hold >= 0) return AW'(rd_hold);
        return AW'($urandom_range(N - 1, 0));
    endfunction

    // One clock: predict from pre-edge inputs, advance, then compare after the edge.
    task automatic step();
        logic [DW-1:0] rd_nxt;
        bit commit_nxt;
        bit acc;
        bit wb;
        int idx;
        check("ready", 32'(s_ready), 32'(!m_commit));
        acc = s_valid && !m_commit;
        rd_nxt = m_mem[m_active][rd_addr];
        exp_q.push_back(rd_nxt);
        wb = SHADOW ? !m_active : 1'b0;
        commit_nxt = 1'b0;
        if (acc) begin
            if (m_discard) begin
                if (s_last) m_discard = 1'b0;
            end else begin
                idx = m_count;
                if (idx == 0) m_err = 1'b0;
                m_mem[wb][idx] = s_data;
                if (s_last) begin
                    m_count = 0;
                    if (idx == N - 1) commit_nxt = 1'b1;
                    else m_err = 1'b1;
                end else if (idx == N - 1) begin
                    m_err = 1'b1;
                    m_discard = 1'b1;
                    m_count = 0;
                end else begin
                    m_count++;
                end
            end
        end
        if (m_commit && SHADOW) m_active = !m_active;
        m_commit = commit_nxt;
        @(posedge clk);
        #1;
        check("done", 32'(done), 32'(m_commit));
        check("err", 32'(err), 32'(m_err));
        check("busy", 32'(busy), 32'(m_count != 0 || m_discard || m_commit));
        check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        if (done) n_done++;
    endtask

    // Asynchronous reset asserted mid-cycle, checked before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        v1 = 1'b0;
        #2;
        m_count = 0;
        m_discard = 1'b0;
        m_commit = 1'b0;
        m_err = 1'b0;
        m_active = 1'b0;
        exp_q.delete();
        check("rst_ready", 32'(s_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_rd", 32'(rd_data), 32'(0));
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst1_rd", 32'(rdd1), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive_beat(input logic [DW-1:0] d, input bit last, input int gap_max);
        int gap;
        bit ok;
        gap = $urandom_range(gap_max, 0);
        repeat (gap) begin
            s_valid = 1'b0;
            s_last = 1'b0;
            rd_addr = next_rd();
            step();
        end
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        rd_addr = next_rd();
        ok = 1'b0;
        for (int t = 0; t < 4 && !ok; t++) begin
            ok = s_ready;
            step();
        end
        check("accept", 32'(ok), 32'(1));
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            s_valid = 1'b0;
            rd_addr = next_rd();
            step();
        end
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] sd [N];
    int bi;
    int ready_low;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < N; a++) m_mem[b][a] = '0;
        #1;
        do_reset();

        // Abandon a frame after 3 beats, then load k*3.
        for (int k = 0; k < 3; k++) drive_beat(DW'($urandom), 1'b0, 1);
        do_reset();
        for (int k = 0; k < N; k++) begin
            drive_beat(DW'(k * 3), k == N - 1, 2);
            if (k == N - 1) check("frame_done", 32'(done), 32'(1));
        end
        idle(1);
        for (int a = 0; a < N; a++) begin
            rd_hold = a;
            idle(1);
            check("sweep_k3", 32'(rd_data), 32'(a * 3));
        end
        rd_hold = -1;

        // Short frame: last on beat 10.
        for (int k = 0; k < 10; k++) begin
            sd[k] = DW'($urandom);
            drive_beat(sd[k], k == 9, 1);
        end
        check("short_err", 32'(err), 32'(1));
        check("short_done", 32'(done), 32'(0));
        idle(1);
        check("short_done2", 32'(done), 32'(0));
        for (int a = 0; a < N; a++) begin
            rd_hold = a;
            idle(1);
            check("sweep_short", 32'(rd_data), (SHADOW || a >= 10) ? 32'(a * 3) : 32'(sd[a]));
        end
        rd_hold = -1;

        // Long frame: 40 beats.
        for (int k = 0; k < 40; k++) begin
            drive_beat(DW'($urandom), k == 39, 1);
            if (k == 31) check("long_err", 32'(err), 32'(1));
            if (k == 31) check("long_disc", 32'(state), 32'(DISCARD));
        end
        check("long_idle", 32'(state), 32'(IDLE));
        for (int k = 0; k < N; k++) begin
            drive_beat(DW'($urandom), k == N - 1, 1);
            if (k == 0) check("err_clear", 32'(err), 32'(0));
        end
        idle(2);

        // Back-to-back frames with valid held high.
        bi = 0;
        ready_low = 0;
        n_done = 0;
        s_valid = 1'b1;
        for (int c = 0; c < 66; c++) begin
            bit was_ready;
            was_ready = s_ready;
            if (!was_ready) ready_low++;
            s_data = DW'($urandom);
            s_last = (bi % N) == N - 1;
            rd_addr = next_rd();
            step();
            if (was_ready) bi++;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        check("b2b_beats", 32'(bi), 32'(64));
        check("b2b_ready_low", 32'(ready_low), 32'(2));
        check("b2b_dones", 32'(n_done), 32'(2));
        idle(1);

        // Same-cycle read/write of address 5.
        for (int k = 0; k < N; k++) drive_beat((k == 5) ? 16'h0011 : DW'($urandom), k == N - 1, 0);
        idle(2);
        for (int k = 0; k < N; k++) begin
            if (k == 5) begin
                rd_hold = 5;
                drive_beat(16'h7FFF, 1'b0, 0);
`ifndef COEF_SHADOW_EN
                check("rw5_old", 32'(rd_data), 32'h0011);
`endif
                idle(1);
`ifndef COEF_SHADOW_EN
                check("rw5_new", 32'(rd_data), 32'h7FFF);
`endif
                rd_hold = -1;
            end else begin
                drive_beat(DW'($urandom), k == N - 1, 0);
            end
        end
        idle(2);

        // Random frames of length 1..40, occasional mid-frame reset.
        for (int f = 0; f < 24; f++) begin
            int len;
            int rst_at;
            len = $urandom_range(40, 1);
            if ($urandom_range(3, 0) == 0) len = N;
            rst_at = ($urandom_range(7, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
            for (int k = 0; k < len; k++) begin
                if (k == rst_at) do_reset();
                drive_beat(DW'($urandom), k == len - 1, 2);
            end
            idle($urandom_range(2, 0));
        end
        idle(2);

        // NUM_COEF = 1 instance.
        v1 = 1'b1;
        d1 = 16'h8000;
        l1 = 1'b1;
        ra1 = '0;
        @(posedge clk);
        #1;
        check("one_done", 32'(dn1), 32'(1));
        check("one_state", 32'(st1), 32'(COMMIT));
        check("one_err", 32'(e1), 32'(0));
        v1 = 1'b0;
        l1 = 1'b0;
        @(posedge clk);
        #1;
        check("one_done_off", 32'(dn1), 32'(0));
        check("one_busy", 32'(b1), 32'(0));
        @(posedge clk);
        #1;
        check("one_rd0", 32'(rdd1), 32'h8000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
